mul_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one pipelined 4x4 unsigned multiplier between NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- Granted operands enter a 2-stage add-tree pipeline: stage 1 forms the partial-sum pair, stage 2 forms the final sum.
- Products return on one response channel tagged with the requester index, with downstream backpressure.

---
 rtl/mul_pkg.sv | 37 +++
 rtl/mul_pipe2.sv | 74 +++++++
 rtl/mul_share_arb.sv | 102 ++++++++++
 tb/tb_mul_share_arb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared widths, grant record and the round-robin pick helper used by the
// multiplier-sharing arbiter.
package mul_pkg;

    localparam int OPW    = 4;   // operand width
    localparam int PRODW  = 8;   // product width
    localparam int MAXREQ = 8;   // largest requester count the helper handles
    localparam int MAXIDW = 3;   // tag width for MAXREQ

    typedef struct packed {
        logic              found;
        logic [MAXIDW-1:0] idx;
    } pick_t;

    // First valid requester at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAXREQ-1:0] valid,
                                      input logic [MAXIDW-1:0] ptr,
                                      input int                n);
        pick_t r;
        int    j;
        r = '0;
        for (int k = 0; k < MAXREQ; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!r.found && valid[j[2:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[MAXIDW-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_pipe2.sv
// Two-stage 4x4 unsigned multiplier add tree. Stage 1 forms the upper and
// lower partial-sum pair, stage 2 adds them. Each stage only loads on its
// advance strobe, so a stalled stage holds its contents.
module mul_pipe2
    import mul_pkg::*;
#(
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [OPW-1:0]   x,
    input  logic [OPW-1:0]   y,
    input  logic [IDW-1:0]   id,
    input  logic             adv1,
    input  logic             adv2,
    output logic             s1_valid,
    output logic             out_valid,
    output logic [PRODW-1:0] product,
    output logic [IDW-1:0]   out_id
);

    logic [PRODW-1:0] x_ext;
    logic [PRODW-1:0] p_hi_next;
    logic [PRODW-1:0] p_lo_next;
    logic [PRODW-1:0] p_hi_reg;
    logic [PRODW-1:0] p_lo_reg;
    logic [IDW-1:0]   s1_id_reg;
    logic             s1_valid_reg;
    logic             s2_valid_reg;
    logic [PRODW-1:0] s2_data_reg;
    logic [IDW-1:0]   s2_id_reg;

    // Shifted-operand partial products, widened so nothing truncates.
    always_comb begin
        x_ext     = PRODW'(x);
        p_hi_next = (y[3] ? (x_ext << 3) : '0) + (y[2] ? (x_ext << 2) : '0);
        p_lo_next = (y[1] ? (x_ext << 1) : '0) + (y[0] ? x_ext : '0);
    end

    // Stage 1: capture the partial-sum pair and tag when allowed to advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_id_reg    <= '0;
            p_hi_reg     <= '0;
            p_lo_reg     <= '0;
        end else if (adv1) begin
            s1_valid_reg <= in_valid;
            s1_id_reg    <= id;
            p_hi_reg     <= p_hi_next;
            p_lo_reg     <= p_lo_next;
        end
    end

    // Stage 2: final sum; holds while the response is backpressured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_id_reg    <= '0;
        end else if (adv2) begin
            s2_valid_reg <= s1_valid_reg;
            s2_data_reg  <= p_hi_reg + p_lo_reg;
            s2_id_reg    <= s1_id_reg;
        end
    end

    assign s1_valid  = s1_valid_reg;
    assign out_valid = s2_valid_reg;
    assign product   = s2_data_reg;
    assign out_id    = s2_id_reg;

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one pipelined 4x4 multiplier between NREQ
// requesters; products return tagged with the issuing requester index.
module mul_share_arb
    import mul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [OPW*NREQ-1:0] req_x,
    input  logic [OPW*NREQ-1:0] req_y,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    output logic [PRODW-1:0]    rsp_data,
    output logic [IDW-1:0]      rsp_id,
    input  logic                rsp_ready,
    output logic                busy
);

    logic [IDW-1:0]    rr_ptr_reg;
    logic [IDW-1:0]    rr_ptr_next;
    logic [MAXREQ-1:0] valid_ext;
    logic [MAXIDW-1:0] ptr_ext;
    pick_t             pick;
    logic [IDW-1:0]    grant_idx;
    logic              xfer;
    logic              adv1;
    logic              adv2;
    logic              s1_valid;
    logic              s2_valid;
    logic [OPW-1:0]    x_arr [NREQ];
    logic [OPW-1:0]    y_arr [NREQ];

    // Widen the request vector and pointer to the helper's fixed width.
    always_comb begin
        valid_ext            = '0;
        valid_ext[NREQ-1:0]  = req_valid;
        ptr_ext              = '0;
        ptr_ext[IDW-1:0]     = rr_ptr_reg;
        pick                 = rr_pick(valid_ext, ptr_ext, NREQ);
        grant_idx            = pick.idx[IDW-1:0];
    end

    // A stage may load when it is empty or the stage after it is moving.
    assign adv2 = !s2_valid || rsp_ready;
    assign adv1 = !s1_valid || adv2;

    // Reset also masks ready so nothing is offered while state is cleared.
    assign xfer = pick.found && adv1 && !rst;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_ready[gi] = xfer && (grant_idx == IDW'(gi));
            assign x_arr[gi]     = req_x[OPW*gi +: OPW];
            assign y_arr[gi]     = req_y[OPW*gi +: OPW];
        end
    endgenerate

    // Pointer moves just past the winner, only when a transfer happens.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (xfer) begin
            if (grant_idx == IDW'(NREQ - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = grant_idx + IDW'(1);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    mul_pipe2 #(
        .IDW(IDW)
    ) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (xfer),
        .x        (x_arr[grant_idx]),
        .y        (y_arr[grant_idx]),
        .id       (grant_idx),
        .adv1     (adv1),
        .adv2     (adv2),
        .s1_valid (s1_valid),
        .out_valid(s2_valid),
        .product  (rsp_data),
        .out_id   (rsp_id)
    );

    assign rsp_valid = s2_valid;
    assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb: table of single-shot products plus
// hand-written sequences for round-robin, backpressure, fairness and reset.
module tb_mul_share_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [4*NREQ-1:0] req_x;
    logic [4*NREQ-1:0] req_y;
    logic [NREQ-1:0] req_ready;
    logic            rsp_valid;
    logic [7:0]      rsp_data;
    logic [IDW-1:0]  rsp_id;
    logic            rsp_ready;
    logic            busy;

    int tests;
    int fails;

    mul_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_x    (req_x),
        .req_y    (req_y),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_id   (rsp_id),
        .rsp_ready(rsp_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int x;
        int y;
        int prod;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input int x, input int y);
        req_valid[i]      = 1'b1;
        req_x[4*i +: 4]   = 4'(x);
        req_y[4*i +: 4]   = 4'(y);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;

        vecs[0] = '{2, 7, 9, 63};
        vecs[1] = '{1, 15, 15, 225};
        vecs[2] = '{0, 15, 0, 0};
        vecs[3] = '{3, 0, 15, 0};
        vecs[4] = '{2, 8, 8, 64};
        vecs[5] = '{1, 5, 3, 15};

        // Reset state, with a request pending to prove ready is masked.
        @(negedge clk);
        set_req(1, 3, 3);
        #1;
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_data",  int'(rsp_data), 0);
        check("reset_rsp_id",    int'(rsp_id), 0);
        check("reset_busy",      int'(busy), 0);
        check("reset_req_ready", int'(req_ready), 0);
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b0;

        // Table of single products: latency, tag and busy window.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            set_req(vecs[v].id, vecs[v].x, vecs[v].y);
            #1;
            check("single_ready", int'(req_ready), 1 << vecs[v].id);
            @(posedge clk);
            #1 req_valid = '0;
            @(negedge clk);
            check("single_lat1_valid", int'(rsp_valid), 0);
            check("single_lat1_busy",  int'(busy), 1);
            @(negedge clk);
            check("single_valid", int'(rsp_valid), 1);
            check("single_data",  int'(rsp_data), vecs[v].prod);
            check("single_id",    int'(rsp_id), vecs[v].id);
            check("single_busy",  int'(busy), 1);
            $display("[TB] vec %0d: req %0d %0d*%0d -> %0d id %0d",
                     v, vecs[v].id, vecs[v].x, vecs[v].y, rsp_data, rsp_id);
            @(negedge clk);
            check("single_drain_valid", int'(rsp_valid), 0);
            check("single_drain_busy",  int'(busy), 0);
        end

        // Round robin: all four valid, grants 0,1,2,3,0 back to back.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 15);
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c < 5) check("rr_ready", int'(req_ready), 1 << (c % 4));
            if (c >= 2) begin
                check("rr_rsp_valid", int'(rsp_valid), 1);
                check("rr_rsp_id",    int'(rsp_id), (c - 2) % 4);
                check("rr_rsp_data",  int'(rsp_data), 15 * ((c - 2) % 4 + 1));
                $display("[TB] rr cycle %0d: rsp %0d id %0d", c, rsp_data, rsp_id);
            end else begin
                check("rr_rsp_idle", int'(rsp_valid), 0);
            end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        check("rr_idle_busy", int'(busy), 0);

        // Backpressure: fill both stages, stall five cycles, then release.
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 3, 4);
        #1 check("bp_ready0", int'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        set_req(1, 5, 6);
        #1 check("bp_ready1", int'(req_ready), 2);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        set_req(2, 2, 2);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_stall_ready", int'(req_ready), 0);
            check("bp_stall_valid", int'(rsp_valid), 1);
            check("bp_stall_data",  int'(rsp_data), 12);
            check("bp_stall_id",    int'(rsp_id), 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", int'(req_ready), 4);
        check("bp_release_data",  int'(rsp_data), 12);
        $display("[TB] bp drain: rsp %0d id %0d", rsp_data, rsp_id);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("bp_drain2_valid", int'(rsp_valid), 1);
        check("bp_drain2_data",  int'(rsp_data), 30);
        check("bp_drain2_id",    int'(rsp_id), 1);
        $display("[TB] bp drain: rsp %0d id %0d", rsp_data, rsp_id);
        @(negedge clk);
        check("bp_drain3_valid", int'(rsp_valid), 1);
        check("bp_drain3_data",  int'(rsp_data), 4);
        check("bp_drain3_id",    int'(rsp_id), 2);
        $display("[TB] bp drain: rsp %0d id %0d", rsp_data, rsp_id);
        @(negedge clk);
        check("bp_empty_valid", int'(rsp_valid), 0);
        check("bp_empty_busy",  int'(busy), 0);

        // Bubble collapse: s2 stalled, s1 empty, one request still enters.
        do_reset();
        rsp_ready = 1'b0;
        set_req(3, 2, 3);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        set_req(0, 1, 1);
        #1 check("bubble_ready", int'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("bubble_hold_data", int'(rsp_data), 6);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bubble_next_data", int'(rsp_data), 1);
        check("bubble_next_id",   int'(rsp_id), 0);
        @(negedge clk);

        // Fairness: requester 3 alone three times, then 0 and 3 together.
        do_reset();
        set_req(3, 1, 1);
        for (int c = 0; c < 3; c++) begin
            #1 check("fair_only3", int'(req_ready), 8);
            @(negedge clk);
        end
        set_req(0, 1, 1);
        #1 check("fair_wrap0", int'(req_ready), 1);
        @(negedge clk);
        #1 check("fair_then3", int'(req_ready), 8);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);

        // Reset mid-operation with both stages full.
        do_reset();
        rsp_ready = 1'b0;
        set_req(0, 9, 9);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        set_req(1, 4, 4);
        @(posedge clk);
        #1 set_req(2, 6, 6);
        set_req(0, 2, 7);
        #2;
        check("mid_full_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(rsp_valid), 0);
        check("mid_rst_busy",  int'(busy), 0);
        check("mid_rst_ready", int'(req_ready), 0);
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("mid_first_grant", int'(req_ready), 1);
        check("mid_no_stale",    int'(rsp_valid), 0);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        check("mid_no_stale2", int'(rsp_valid), 0);
        @(negedge clk);
        check("mid_new_valid", int'(rsp_valid), 1);
        check("mid_new_data",  int'(rsp_data), 14);
        check("mid_new_id",    int'(rsp_id), 0);
        $display("[TB] post-reset: rsp %0d id %0d", rsp_data, rsp_id);
        @(negedge clk);
        check("mid_end_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
